// File: rtl/jump_ctrl_if.sv
// Bundle between the decode stage and the jump/branch control unit.
// master = upstream decode (drives operands), slave = jump_ctrl_unit.
interface jump_ctrl_if #(
    parameter int WIDTH = 16
);
    logic             valid_in;
    logic [4:0]       op;
    logic [WIDTH-1:0] pc_plus2;
    logic [WIDTH-1:0] imm;
    logic [WIDTH-1:0] rs_val;
    logic             rs_ready;
    logic             stall_out;
    logic             redirect;
    logic [WIDTH-1:0] target;
    logic             link_we;
    logic [WIDTH-1:0] link_data;
    logic             flush;

    // Handshake: an op is taken when valid_in=1 and stall_out=0; while
    // stall_out=1 upstream holds its inputs and valid_in is not consumed.
    modport master (
        output valid_in, op, pc_plus2, imm, rs_val, rs_ready,
        input  stall_out, redirect, target, link_we, link_data, flush
    );

    modport slave (
        input  valid_in, op, pc_plus2, imm, rs_val, rs_ready,
        output stall_out, redirect, target, link_we, link_data, flush
    );
endinterface

// File: rtl/jump_ctrl_unit.sv
// Jump/branch resolution: computes redirect targets, link writes and a
// fixed-length flush window; waits for Rs when the operand is not ready.
module jump_ctrl_unit #(
    parameter int WIDTH        = 16,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    jump_ctrl_if.slave bus,
    output logic [1:0] fsm_state
);
    localparam int CW = $clog2(FLUSH_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_RS = 2'd1,
        FLUSH   = 2'd2
    } state_t;

    state_t           state, next_state;
    logic [CW-1:0]    cnt, next_cnt;
    logic [4:0]       lat_op;
    logic [WIDTH-1:0] lat_pc, lat_imm;
    logic [4:0]       cur_op;
    logic [WIDTH-1:0] cur_pc, cur_imm, calc_target;
    logic             is_ctrl, is_branch, is_jump, needs_rs, is_link;
    logic             cond, taken, fire, do_redirect;
    logic             redirect_q, link_we_q;
    logic [WIDTH-1:0] target_q, link_data_q;

    // While waiting on Rs the latched op is authoritative, not the live bus.
    always_comb begin
        cur_op  = (state == WAIT_RS) ? lat_op  : bus.op;
        cur_pc  = (state == WAIT_RS) ? lat_pc  : bus.pc_plus2;
        cur_imm = (state == WAIT_RS) ? lat_imm : bus.imm;

        is_ctrl   = !cur_op[4] && cur_op[2];
        is_branch = is_ctrl && cur_op[3];
        is_jump   = is_ctrl && !cur_op[3];
        needs_rs  = is_branch || (is_jump && cur_op[0]);
        is_link   = is_jump && cur_op[1];

        case (cur_op[1:0])
            2'b00:   cond = (bus.rs_val == '0);
            2'b01:   cond = (bus.rs_val != '0);
            2'b10:   cond = bus.rs_val[WIDTH-1];
            default: cond = !bus.rs_val[WIDTH-1];
        endcase
        taken = is_jump || (is_branch && cond);

        calc_target = (is_jump && cur_op[0]) ? (bus.rs_val + cur_imm)
                                             : (cur_pc + cur_imm);

        case (state)
            IDLE:    fire = bus.valid_in && is_ctrl && (!needs_rs || bus.rs_ready);
            WAIT_RS: fire = bus.rs_ready;
            default: fire = 1'b0;
        endcase
        do_redirect = fire && taken;
    end

    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        case (state)
            IDLE: begin
                if (bus.valid_in && is_ctrl && needs_rs && !bus.rs_ready) begin
                    next_state = WAIT_RS;
                end else if (do_redirect) begin
                    next_state = FLUSH;
                    next_cnt   = CW'(FLUSH_CYCLES);
                end
            end
            WAIT_RS: begin
                if (do_redirect) begin
                    next_state = FLUSH;
                    next_cnt   = CW'(FLUSH_CYCLES);
                end else if (bus.rs_ready) begin
                    next_state = IDLE;
                end
            end
            FLUSH: begin
                if (cnt <= CW'(1)) begin
                    next_state = IDLE;
                    next_cnt   = '0;
                end else begin
                    next_cnt = cnt - CW'(1);
                end
            end
            default: begin
                next_state = IDLE;
                next_cnt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
        end
    end

    always_ff @(posedge clk) begin
        if (state == IDLE) begin
            lat_op  <= bus.op;
            lat_pc  <= bus.pc_plus2;
            lat_imm <= bus.imm;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            redirect_q  <= 1'b0;
            link_we_q   <= 1'b0;
            target_q    <= '0;
            link_data_q <= '0;
        end else begin
            redirect_q <= do_redirect;
            link_we_q  <= do_redirect && is_link;
            if (do_redirect) target_q <= calc_target;
            if (do_redirect && is_link) link_data_q <= cur_pc;
        end
    end

    assign bus.stall_out = (state != IDLE);
    assign bus.flush     = (state == FLUSH);
    assign bus.redirect  = redirect_q;
    assign bus.link_we   = link_we_q;
    assign bus.target    = target_q;
    assign bus.link_data = link_data_q;
    assign fsm_state     = state;
endmodule

// File: tb/tb_jump_ctrl_unit.sv
// Directed bench for jump_ctrl_unit: vector table for single ops plus
// hand sequences for Rs wait, back-to-back branches, flush and reset.
module tb_jump_ctrl_unit;
    logic clk;
    logic rst;
    logic [1:0] st_a, st_b;
    int checks;
    int failures;
    logic [15:0] last_target;
    logic [15:0] last_link;

    jump_ctrl_if #(.WIDTH(16)) ia ();
    jump_ctrl_if #(.WIDTH(16)) ib ();

    jump_ctrl_unit #(.WIDTH(16), .FLUSH_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .bus(ia), .fsm_state(st_a)
    );
    jump_ctrl_unit #(.WIDTH(16), .FLUSH_CYCLES(5)) dut5 (
        .clk(clk), .rst(rst), .bus(ib), .fsm_state(st_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  op;
        logic [15:0] pc;
        logic [15:0] imm;
        logic [15:0] rs;
        logic        rdy;
        logic        red;
        logic [15:0] tgt;
        logic        lw;
        logic [15:0] ld;
    } vec_t;

    vec_t vecs[15];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] o, input logic [15:0] p,
                         input logic [15:0] i, input logic [15:0] r, input logic rdy);
        ia.valid_in = v; ia.op = o; ia.pc_plus2 = p; ia.imm = i; ia.rs_val = r; ia.rs_ready = rdy;
        ib.valid_in = v; ib.op = o; ib.pc_plus2 = p; ib.imm = i; ib.rs_val = r; ib.rs_ready = rdy;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((ia.stall_out || ib.stall_out) && n < 20) begin
            step();
            n++;
        end
        check("wait_idle_timeout", 32'(n >= 20), 32'd0);
    endtask

    task automatic check_quiet(input string name);
        check({name, "_redirect"}, 32'(ia.redirect), 32'd0);
        check({name, "_link_we"},  32'(ia.link_we),  32'd0);
        check({name, "_flush"},    32'(ia.flush),    32'd0);
        check({name, "_stall"},    32'(ia.stall_out), 32'd0);
    endtask

    initial begin
        int f2, f5;
        checks = 0;
        failures = 0;
        last_target = 16'h0000;
        last_link = 16'h0000;

        //             op        pc       imm      rs       rdy red tgt     lw ld
        vecs[0]  = '{5'b00110, 16'h0100, 16'h0010, 16'h0000, 1, 1, 16'h0110, 1, 16'h0100};
        vecs[1]  = '{5'b00100, 16'hFFFE, 16'h0004, 16'h0000, 1, 1, 16'h0002, 0, 16'h0000};
        vecs[2]  = '{5'b00101, 16'h0040, 16'hFFFE, 16'h2000, 1, 1, 16'h1FFE, 0, 16'h0000};
        vecs[3]  = '{5'b00111, 16'h0302, 16'h0020, 16'h1000, 1, 1, 16'h1020, 1, 16'h0302};
        vecs[4]  = '{5'b01100, 16'h0200, 16'h0100, 16'h0000, 1, 1, 16'h0300, 0, 16'h0000};
        vecs[5]  = '{5'b01100, 16'h0200, 16'h0100, 16'h0001, 1, 0, 16'h0000, 0, 16'h0000};
        vecs[6]  = '{5'b01101, 16'h0200, 16'hFFF0, 16'h0001, 1, 1, 16'h01F0, 0, 16'h0000};
        vecs[7]  = '{5'b01101, 16'h0200, 16'hFFF0, 16'h0000, 1, 0, 16'h0000, 0, 16'h0000};
        vecs[8]  = '{5'b01110, 16'h0400, 16'h0008, 16'h8000, 1, 1, 16'h0408, 0, 16'h0000};
        vecs[9]  = '{5'b01110, 16'h0400, 16'h0008, 16'h0005, 1, 0, 16'h0000, 0, 16'h0000};
        vecs[10] = '{5'b01111, 16'h0500, 16'h0002, 16'h0000, 1, 1, 16'h0502, 0, 16'h0000};
        vecs[11] = '{5'b01111, 16'h0500, 16'h0002, 16'hFFFF, 1, 0, 16'h0000, 0, 16'h0000};
        vecs[12] = '{5'b00000, 16'h0600, 16'h0002, 16'h0000, 1, 0, 16'h0000, 0, 16'h0000};
        vecs[13] = '{5'b10110, 16'h0600, 16'h0002, 16'h0000, 1, 0, 16'h0000, 0, 16'h0000};
        vecs[14] = '{5'b00100, 16'h1000, 16'h0100, 16'h0000, 0, 1, 16'h1100, 0, 16'h0000};

        // Reset, with a control op presented at the same time.
        rst = 1'b1;
        drive(1'b1, 5'b00110, 16'h0100, 16'h0010, 16'h0000, 1'b1);
        step();
        step();
        check_quiet("reset");
        check("reset_target", 32'(ia.target), 32'h0);
        check("reset_link_data", 32'(ia.link_data), 32'h0);
        check("reset_state", 32'(st_a), 32'd0);
        drive(1'b0, 5'b00000, 16'h0, 16'h0, 16'h0, 1'b0);
        rst = 1'b0;
        step();
        check_quiet("post_reset");

        for (int k = 0; k < 15; k++) begin
            wait_idle();
            drive(1'b1, vecs[k].op, vecs[k].pc, vecs[k].imm, vecs[k].rs, vecs[k].rdy);
            step();
            ia.valid_in = 1'b0;
            ib.valid_in = 1'b0;
            if (vecs[k].red) last_target = vecs[k].tgt;
            if (vecs[k].lw) last_link = vecs[k].ld;
            check($sformatf("v%0d_redirect", k), 32'(ia.redirect), 32'(vecs[k].red));
            check($sformatf("v%0d_target", k), 32'(ia.target), 32'(last_target));
            check($sformatf("v%0d_link_we", k), 32'(ia.link_we), 32'(vecs[k].lw));
            check($sformatf("v%0d_link_data", k), 32'(ia.link_data), 32'(last_link));
            check($sformatf("v%0d_flush", k), 32'(ia.flush), 32'(vecs[k].red));
            check($sformatf("v%0d_stall", k), 32'(ia.stall_out), 32'(vecs[k].red));
            check($sformatf("v%0d_redirect5", k), 32'(ib.redirect), 32'(vecs[k].red));
            if (vecs[k].red) begin
                f2 = 1;
                f5 = 1;
                for (int i = 0; i < 7; i++) begin
                    step();
                    f2 += int'(ia.flush);
                    f5 += int'(ib.flush);
                    if (ia.redirect) check($sformatf("v%0d_second_redirect", k), 32'd1, 32'd0);
                end
                check($sformatf("v%0d_flush_len2", k), 32'(f2), 32'd2);
                check($sformatf("v%0d_flush_len5", k), 32'(f5), 32'd5);
                check($sformatf("v%0d_idle_after", k), 32'(ia.stall_out), 32'd0);
            end else begin
                step();
                check($sformatf("v%0d_quiet_next", k), 32'(ia.redirect), 32'd0);
            end
        end

        // JR waits 3 cycles on Rs; live inputs change meanwhile and are ignored.
        wait_idle();
        drive(1'b1, 5'b00101, 16'h0040, 16'hFFFE, 16'h0000, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            drive(1'b0, 5'b00100, 16'h0000, 16'h0000, 16'h0000, 1'b0);
            check($sformatf("jr_wait%0d_stall", i), 32'(ia.stall_out), 32'd1);
            check($sformatf("jr_wait%0d_redirect", i), 32'(ia.redirect), 32'd0);
        end
        drive(1'b0, 5'b00000, 16'h0000, 16'h0000, 16'h2000, 1'b1);
        step();
        check("jr_redirect", 32'(ia.redirect), 32'd1);
        check("jr_target", 32'(ia.target), 32'h1FFE);
        check("jr_link_we", 32'(ia.link_we), 32'd0);
        last_target = 16'h1FFE;
        drive(1'b0, 5'b00000, 16'h0000, 16'h0000, 16'h0000, 1'b0);
        wait_idle();

        // Back-to-back BLTZ: not-taken then taken on the very next cycle.
        drive(1'b1, 5'b01110, 16'h0600, 16'h0010, 16'h0005, 1'b1);
        step();
        check("bltz1_redirect", 32'(ia.redirect), 32'd0);
        check("bltz1_flush", 32'(ia.flush), 32'd0);
        check("bltz1_stall", 32'(ia.stall_out), 32'd0);
        drive(1'b1, 5'b01110, 16'h0700, 16'h0010, 16'h8000, 1'b1);
        step();
        drive(1'b0, 5'b00000, 16'h0000, 16'h0000, 16'h0000, 1'b0);
        check("bltz2_redirect", 32'(ia.redirect), 32'd1);
        check("bltz2_target", 32'(ia.target), 32'h0710);
        last_target = 16'h0710;
        wait_idle();

        // J with wrap, JAL held on valid_in throughout FLUSH is ignored.
        drive(1'b1, 5'b00100, 16'hFFFE, 16'h0004, 16'h0000, 1'b1);
        step();
        check("jwrap_target", 32'(ia.target), 32'h0002);
        check("jwrap_redirect", 32'(ia.redirect), 32'd1);
        drive(1'b1, 5'b00110, 16'h0100, 16'h0010, 16'h0000, 1'b1);
        step();
        check("flush_jal_redirect", 32'(ia.redirect), 32'd0);
        check("flush_jal_link_we", 32'(ia.link_we), 32'd0);
        check("flush_jal_flush", 32'(ia.flush), 32'd1);
        drive(1'b0, 5'b00000, 16'h0000, 16'h0000, 16'h0000, 1'b0);
        step();
        check_quiet("flush_jal_after");
        check("flush_jal_target_hold", 32'(ia.target), 32'h0002);
        wait_idle();

        // Reset in WAIT_RS aborts; a late rs_ready must not redirect.
        drive(1'b1, 5'b01100, 16'h0800, 16'h0010, 16'h0000, 1'b0);
        step();
        check("wrs_state", 32'(st_a), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        drive(1'b0, 5'b00000, 16'h0000, 16'h0000, 16'h0000, 1'b1);
        step();
        check_quiet("wrs_abort");
        check("wrs_abort_target", 32'(ia.target), 32'h0);
        check("wrs_abort_link_data", 32'(ia.link_data), 32'h0);
        check("wrs_abort_state", 32'(st_a), 32'd0);
        drive(1'b1, 5'b10000, 16'h0900, 16'h0010, 16'h0000, 1'b1);
        step();
        drive(1'b0, 5'b00000, 16'h0000, 16'h0000, 16'h0000, 1'b0);
        step();
        check_quiet("nonctrl");

        // Reset in FLUSH aborts the flush window.
        drive(1'b1, 5'b00110, 16'h0A00, 16'h0010, 16'h0000, 1'b1);
        step();
        check("rflush_redirect", 32'(ia.redirect), 32'd1);
        drive(1'b0, 5'b00000, 16'h0000, 16'h0000, 16'h0000, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_quiet("rflush_abort");
        check("rflush_link_data", 32'(ia.link_data), 32'h0);
        step();
        check_quiet("rflush_after");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/jump_ctrl_unit.md
JUMP_CTRL_UNIT -- requirements
Module: jump_ctrl_unit

Interface
REQ-001 Parameter WIDTH, default 16, sets the PC/data width in bits; legal range 8..32.
REQ-002 Parameter FLUSH_CYCLES, default 2, sets the flush pulse length in cycles after a redirect; legal range 1..7.
REQ-003 clk  in  1  the single clock; all state updates on its rising edge.
REQ-004 rst  in  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 valid_in  in  1  op/pc_plus2/imm are valid this cycle.
REQ-006 op  in  5  instruction opcode.
REQ-007 pc_plus2  in  WIDTH  address of the next sequential instruction.
REQ-008 imm  in  WIDTH  displacement, already sign-extended.
REQ-009 rs_val  in  WIDTH  Rs operand value.
REQ-010 rs_ready  in  1  rs_val holds the current Rs value.
REQ-011 stall_out  out  1  the block is not accepting; upstream holds its inputs.
REQ-012 redirect  out  1  one-cycle pulse; fetch loads target.
REQ-013 target  out  WIDTH  redirect address; valid only while redirect=1.
REQ-014 link_we  out  1  one-cycle pulse; write link_data to R7.
REQ-015 link_data  out  WIDTH  return address.
REQ-016 flush  out  1  squash the younger in-flight instructions.

Function
REQ-017 The block SHALL decode these opcodes:
- J 00100, JR 00101, JAL 00110, JALR 00111
- BEQZ 01100, BNEZ 01101, BLTZ 01110, BGEZ 01111
- all other opcodes are non-control; they are ignored and produce no output activity.
REQ-018 Target computation, mod 2^WIDTH (wrap-around, no overflow flag):
- J, JAL and taken branches SHALL use target = pc_plus2 + imm.
- JR and JALR SHALL use target = rs_val + imm.
REQ-019 Branch conditions SHALL evaluate rs_val as signed: BEQZ ==0, BNEZ !=0, BLTZ <0, BGEZ >=0.
REQ-020 "Needs Rs" ops are JR, JALR and all branches; J and JAL never wait on rs_ready.
REQ-021 The FSM SHALL have exactly three states: IDLE, WAIT_RS, FLUSH.
REQ-022 In IDLE with valid_in=1 and a control op:
- If the op needs Rs and rs_ready=0, the block SHALL latch op, pc_plus2 and imm, and go to WAIT_RS.
- Otherwise it SHALL accept the op this cycle (cycle N).
REQ-023 In WAIT_RS:
- stall_out SHALL be 1.
- New inputs SHALL be ignored; the latched op/pc_plus2/imm are used.
- The op SHALL be accepted in the first cycle with rs_ready=1, sampling rs_val in that cycle.
REQ-024 On acceptance in cycle N of a J, JR, JAL, JALR or taken branch:
- redirect=1 and target are registered and SHALL be valid in cycle N+1 only.
- The FSM SHALL enter FLUSH in cycle N+1.
REQ-025 On acceptance of a JAL or JALR, link_we=1 and link_data=pc_plus2 of that op SHALL be asserted in cycle N+1, coincident with redirect.
REQ-026 A not-taken branch SHALL produce no redirect, no flush and no link write; the FSM returns to or stays in IDLE, and a new op SHALL be accepted in cycle N+1.
REQ-027 In FLUSH:
- flush=1 and stall_out=1 SHALL hold for exactly FLUSH_CYCLES cycles, starting at N+1.
- valid_in SHALL be ignored throughout.
- The FSM then returns to IDLE.
REQ-028 The flush counter SHALL be clog2(FLUSH_CYCLES+1) bits wide and SHALL load FLUSH_CYCLES on entry to FLUSH.
REQ-029 stall_out SHALL be combinational from state only: 1 in WAIT_RS and FLUSH, 0 in IDLE.
REQ-030 redirect, link_we, target and link_data SHALL be registered outputs.
REQ-031 target and link_data SHALL hold their last value when redirect=0.

Reset
REQ-032 When rst=1 at a clock edge, the block SHALL set:
- FSM = IDLE, counter = 0
- redirect = link_we = flush = 0
- target = link_data = 0
REQ-033 rst SHALL take priority over all other inputs, including valid_in in the same cycle.
REQ-034 Reset asserted in WAIT_RS or FLUSH SHALL abort the operation; no redirect or link write SHALL follow.

Verification
REQ-035 JAL, pc_plus2=0x0100, imm=0x0010 -> cycle N+1: redirect=1, target=0x0110, link_we=1, link_data=0x0100; flush=1 for N+1..N+2; stall_out=0 at N+3.
REQ-036 JR with rs_ready=0 for 3 cycles, then rs_val=0x2000, imm=0xFFFE -> stall_out=1 for those 3 cycles; redirect with target=0x1FFE one cycle after rs_ready rises; link_we=0.
REQ-037 BLTZ with rs_val=0x0005, then BLTZ with rs_val=0x8000 on the next cycle -> first: no redirect, no flush; second accepted back-to-back, redirect with target=pc_plus2+imm.
REQ-038 J, pc_plus2=0xFFFE, imm=0x0004 -> target=0x0002 (wrap); valid_in=1 with JAL during FLUSH -> ignored, no second redirect.
REQ-039 rst=1 while in WAIT_RS, then rs_ready=1 -> no redirect, all outputs 0, FSM IDLE; a non-control op with valid_in=1 -> no output activity.
REQ-040 FLUSH_CYCLES=5 build -> flush high exactly 5 cycles after each redirect.
